mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory (iccm/dccm-style port: raddr/rvalid_in/rdata/rvalid_out/waddr/wen/wdata) between the IFU fetch path and the EXU LSU.
- LSU has priority by default; a starvation counter guarantees IFU progress.
- Tracks in-flight reads in a small source FIFO and routes each returning read to its requester.
- Discards IFU responses made stale by a pipeline flush.

Parameters:
ADDR_WIDTH, 32, request/memory address width
DATA_WIDTH, 32, memory data width
TAG_WIDTH, 32, IFU fetch tag width, carried through to the response
MAX_OUTSTANDING, 2, depth of the in-flight read source FIFO (power of 2, ≥1)
STARVE_LIMIT, 4, consecutive IFU-blocked cycles that force one IFU grant (≥1)

Ports:
clk  in  1  core clock
rstn  in  1  async active-low reset
flush  in  1  pipeline flush (pc_load); kills in-flight IFU reads
if_req_valid  in  1  IFU fetch request
if_req_addr  in  ADDR_WIDTH  fetch address
if_req_tag  in  TAG_WIDTH  fetch tag
if_req_ready  out  1  IFU request accepted this cycle
if_rsp_valid  out  1  fetch data valid
if_rsp_data  out  DATA_WIDTH  fetch data
if_rsp_tag  out  TAG_WIDTH  tag of returned fetch
ls_req_valid  in  1  LSU request
ls_req_we  in  1  1 = write, 0 = read
ls_req_addr  in  ADDR_WIDTH  LSU address
ls_req_wdata  in  DATA_WIDTH  store data
ls_req_ready  out  1  LSU request accepted this cycle
ls_rsp_valid  out  1  load data valid
ls_rsp_data  out  DATA_WIDTH  load data
mem_raddr  out  ADDR_WIDTH  memory read address
mem_rvalid_in  out  1  memory read strobe
mem_rdata  in  DATA_WIDTH  memory read data
mem_rvalid_out  in  1  memory read data valid
mem_waddr  out  ADDR_WIDTH  memory write address
mem_wen  out  1  memory write strobe
mem_wdata  out  DATA_WIDTH  memory write data
perf_if_stall  out  32  IFU blocked-cycle count (optional feature)
perf_ls_stall  out  32  LSU blocked-cycle count (optional feature)

Behaviour:
- Reset (async, rstn low): all outputs 0. FIFO empty, starvation counter 0, perf counters 0.
- Handshake: valid/ready. Ready is combinational and asserted only in the grant cycle. A requester holds valid/addr/data stable until ready.
- Memory issue:
  - Requests are issued combinationally in the grant cycle: mem_rvalid_in = granted read; mem_wen = granted write.
  - Memory read latency is ≥1 cycle and returns in order.
- Eligibility:
  - A read needs FIFO not full. A read issued in the same cycle as a pop counts against the post-pop occupancy (pop frees the slot first).
  - A write is always eligible and pushes nothing.
- Arbitration, each cycle:
  - force_if = (starve_cnt == STARVE_LIMIT).
  - If force_if and IFU eligible, grant IFU. Otherwise grant LSU if eligible, else IFU if eligible.
  - Only one grant per cycle.
- Starvation counter:
  - Increments when if_req_valid and IFU is not granted; saturates at STARVE_LIMIT.
  - Clears on IFU grant or when if_req_valid = 0.
- Source FIFO:
  - Each read grant pushes {src, killed=0, tag}.
  - Each mem_rvalid_out pops the head and routes mem_rdata:
    - src = LSU → ls_rsp_valid.
    - src = IFU and not killed → if_rsp_valid with the stored tag.
    - src = IFU and killed → dropped; no response.
  - Responses are combinational from mem_rvalid_out; 0-cycle added latency.
- Flush:
  - Sets killed on every IFU entry in the FIFO.
  - Also kills an IFU read granted in the flush cycle.
  - A response arriving in the flush cycle is suppressed if it is IFU.
  - LSU entries are unaffected.
- Boundary cases:
  - mem_rvalid_out with FIFO empty is a protocol error; ignore it (assertion in sim).
  - Simultaneous push and pop when full is allowed per the eligibility rule.
  - Pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
MEM_ARB_PERF_CNT_EN
- Defined: perf_if_stall increments each cycle if_req_valid && !if_req_ready; perf_ls_stall likewise for the LSU. Both saturate at 32'hFFFF_FFFF and clear only on reset.
- Undefined: both ports tied to 0 and no counter flops exist.

Test Plan:
- Both request reads at addresses 0x10 (IFU) and 0x20 (LSU), STARVE_LIMIT = 4 → LSU granted first. Next cycle IFU granted. Responses return in order: ls_rsp then if_rsp carrying the IFU tag.
- LSU reads continuously while IFU holds a request → IFU granted on the 5th blocked cycle (starve_cnt = 4), then LSU resumes.
- MAX_OUTSTANDING = 2, memory stalls its responses → third read not granted until mem_rvalid_out. A grant in the same cycle as the pop is accepted.
- Two IFU reads in flight, flush pulsed → both responses dropped (if_rsp_valid stays 0). A following LSU load still returns ls_rsp_valid with the correct data.
- LSU write to 0x40 with data 0xDEADBEEF while FIFO is full → mem_wen = 1, mem_waddr = 0x40, mem_wdata = 0xDEADBEEF in the grant cycle. No FIFO push.
- With MEM_ARB_PERF_CNT_EN, IFU blocked for 7 cycles → perf_if_stall = 7. Without the macro → perf_if_stall = 0. Reset asserted mid-flight → all outputs 0, FIFO empty.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IFU fetch and LSU, routing in-order read returns
// Optional MEM_ARB_PERF_CNT_EN adds saturating blocked-cycle counters for both requesters.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    input  logic [TAG_WIDTH-1:0]  if_req_tag,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    output logic [TAG_WIDTH-1:0]  if_rsp_tag,
    input  logic                  ls_req_valid,
    input  logic                  ls_req_we,
    input  logic [ADDR_WIDTH-1:0] ls_req_addr,
    input  logic [DATA_WIDTH-1:0] ls_req_wdata,
    output logic                  ls_req_ready,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_rvalid_in,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid_out,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [31:0]           perf_if_stall,
    output logic [31:0]           perf_ls_stall
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW-1:0] LAST  = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] FULL  = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic                 src_q  [MAX_OUTSTANDING];
    logic                 kill_q [MAX_OUTSTANDING];
    logic [TAG_WIDTH-1:0] tag_q  [MAX_OUTSTANDING];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [SW-1:0]        starve_cnt;
    logic                 pop, rd_ok, if_elig, ls_elig, force_if;
    logic                 grant_if, grant_ls, ls_rd, push, head_if;

    // A pop frees its slot before a same-cycle read is checked for room.
    assign pop      = mem_rvalid_out && (count != '0);
    assign rd_ok    = (count != FULL) || pop;
    // Grants are held off while reset is asserted so every output reads 0.
    assign if_elig  = rstn && if_req_valid && rd_ok;
    assign ls_elig  = rstn && ls_req_valid && (ls_req_we || rd_ok);
    assign force_if = starve_cnt == LIMIT;
    assign grant_if = if_elig && (force_if || !ls_elig);
    assign grant_ls = ls_elig && !grant_if;
    assign ls_rd    = grant_ls && !ls_req_we;
    assign push     = grant_if || ls_rd;

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_rvalid_in = push;
    assign mem_raddr     = grant_if ? if_req_addr : ls_rd ? ls_req_addr : '0;
    assign mem_wen       = grant_ls && ls_req_we;
    assign mem_waddr     = mem_wen ? ls_req_addr : '0;
    assign mem_wdata     = mem_wen ? ls_req_wdata : '0;

    // A returning IFU read is dropped if it was flushed earlier or a flush arrives with it.
    assign head_if      = src_q[rd_ptr];
    assign ls_rsp_valid = pop && !head_if;
    assign if_rsp_valid = pop && head_if && !kill_q[rd_ptr] && !flush;
    assign ls_rsp_data  = ls_rsp_valid ? mem_rdata : '0;
    assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
    assign if_rsp_tag   = if_rsp_valid ? tag_q[rd_ptr] : '0;

    // In-flight read source FIFO: push on read grant, pop on memory return, flush kills IFU entries.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                src_q[i]  <= 1'b0;
                kill_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                if (flush && src_q[i]) kill_q[i] <= 1'b1;
            if (push) begin
                src_q[wr_ptr]  <= grant_if;
                kill_q[wr_ptr] <= flush && grant_if;
                tag_q[wr_ptr]  <= grant_if ? if_req_tag : '0;
                wr_ptr         <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Starvation counter: counts consecutive blocked IFU cycles, saturating at the force threshold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) starve_cnt <= '0;
        else starve_cnt <= (!if_req_valid || grant_if) ? '0 : force_if ? starve_cnt : starve_cnt + SW'(1);
    end

    // Returning data with nothing in flight is a memory protocol error; the pop logic ignores it.
    always_ff @(posedge clk) begin
        if (rstn) assert (!(mem_rvalid_out && count == '0));
    end

`ifdef MEM_ARB_PERF_CNT_EN
    // Saturating blocked-cycle counters, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_if_stall <= '0;
            perf_ls_stall <= '0;
        end else begin
            if (if_req_valid && !grant_if && perf_if_stall != '1) perf_if_stall <= perf_if_stall + 32'd1;
            if (ls_req_valid && !grant_ls && perf_ls_stall != '1) perf_ls_stall <= perf_ls_stall + 32'd1;
        end
    end
`else
    assign perf_if_stall = '0;
    assign perf_ls_stall = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a queue-based model
module tb_mem_port_arbiter;
    localparam int MAX = 2;
    localparam int LIM = 4;
`ifdef MEM_ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr = '0, if_req_tag = '0, if_rsp_data, if_rsp_tag;
    logic        ls_req_valid = 1'b0, ls_req_we = 1'b0, ls_req_ready, ls_rsp_valid;
    logic [31:0] ls_req_addr = '0, ls_req_wdata = '0, ls_rsp_data;
    logic [31:0] mem_raddr, mem_rdata = '0, mem_waddr, mem_wdata;
    logic        mem_rvalid_in, mem_rvalid_out = 1'b0, mem_wen;
    logic [31:0] perf_if_stall, perf_ls_stall;

    int checks = 0, errors = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(32),
                       .MAX_OUTSTANDING(MAX), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_tag(if_req_tag),
        .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .if_rsp_tag(if_rsp_tag), .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .mem_raddr(mem_raddr),
        .mem_rvalid_in(mem_rvalid_in), .mem_rdata(mem_rdata), .mem_rvalid_out(mem_rvalid_out),
        .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .perf_if_stall(perf_if_stall), .perf_ls_stall(perf_ls_stall));

    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory model: in-order reads with per-read latency and an optional stall.
    typedef struct { int due; logic [31:0] addr; } mreq_t;
    mreq_t mq[$];
    int    mcyc = 0, lat = 1;
    bit    mem_stall = 1'b0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            mem_rvalid_out = 1'b0;
            mem_rdata = '0;
        end else begin
            if (mem_rvalid_out && mq.size() > 0) void'(mq.pop_front());
            mcyc++;
            if (mem_rvalid_in) mq.push_back('{mcyc + lat - 1, mem_raddr});
            #1;
            mem_rvalid_out = !mem_stall && mq.size() > 0 && mq[0].due <= mcyc;
            mem_rdata = mem_rvalid_out ? f(mq[0].addr) : $urandom;
        end
    end

    // Reference model: outstanding reads as a queue, expected outputs derived from the arbitration rules.
    typedef struct packed {
        logic gi, gl, rd, wen, lsv, ifv;
        logic [31:0] raddr, waddr, wdata, lsd, ifd, ift;
    } exp_t;
    typedef struct { bit src_if; bit killed; logic [31:0] tag; logic [31:0] addr; } ent_t;
    ent_t sb[$];
    int   starve = 0, pif = 0, pls = 0;
    exp_t me;

    function automatic exp_t model_exp();
        exp_t e = '0;
        bit pop, room, ie, le;
        pop  = mem_rvalid_out && sb.size() > 0;
        room = (sb.size() - int'(pop)) < MAX;
        ie   = if_req_valid && room;
        le   = ls_req_valid && (ls_req_we || room);
        e.gi = ie && (starve == LIM || !le);
        e.gl = le && !e.gi;
        e.rd = e.gi || (e.gl && !ls_req_we);
        e.wen = e.gl && ls_req_we;
        e.raddr = e.gi ? if_req_addr : ls_req_addr;
        e.waddr = ls_req_addr;
        e.wdata = ls_req_wdata;
        if (pop) begin
            e.lsv = !sb[0].src_if;
            e.ifv = sb[0].src_if && !sb[0].killed && !flush;
            e.lsd = f(sb[0].addr);
            e.ifd = e.lsd;
            e.ift = sb[0].tag;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb.delete();
            starve = 0;
            pif = 0;
            pls = 0;
        end else begin
            me = model_exp();
            if (if_req_valid && !me.gi) pif++;
            if (ls_req_valid && !me.gl) pls++;
            starve = (!if_req_valid || me.gi) ? 0 : (starve < LIM ? starve + 1 : starve);
            foreach (sb[k]) if (flush && sb[k].src_if) sb[k].killed = 1'b1;
            if (mem_rvalid_out && sb.size() > 0) void'(sb.pop_front());
            if (me.rd) sb.push_back('{me.gi, flush && me.gi, me.gi ? if_req_tag : 32'h0, me.raddr});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        ls_req_valid = 1'b1; ls_req_addr = 32'h20;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({if_req_ready, ls_req_ready, mem_rvalid_in, mem_wen} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {if_req_ready, ls_req_ready, mem_rvalid_in, mem_wen}); end
        checks++; if ({mem_raddr, mem_waddr, mem_wdata} !== 96'h0) begin errors++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_raddr, mem_waddr, mem_wdata}); end
        checks++; if ({if_rsp_valid, ls_rsp_valid} !== 2'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 00", {if_rsp_valid, ls_rsp_valid}); end
        checks++; if ({perf_if_stall, perf_ls_stall} !== 64'h0) begin errors++; $display("FAIL reset_perf: got %h expected 0", {perf_if_stall, perf_ls_stall}); end
        @(posedge clk); #1;
        rstn = 1'b1; if_req_valid = 1'b0; ls_req_valid = 1'b0;
        tick;
    endtask

    task automatic test_priority;
        int ls_at = -1, if_at = -1;
        lat = 2;
        if_req_valid = 1'b1; if_req_addr = 32'h10; if_req_tag = 32'hAB;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h20;
        @(negedge clk);
        checks++; if ({if_req_ready, ls_req_ready} !== 2'b01) begin errors++; $display("FAIL prio_first_grant: got if/ls %b expected 01", {if_req_ready, ls_req_ready}); end
        checks++; if (mem_raddr !== 32'h20) begin errors++; $display("FAIL prio_first_raddr: got %h expected 20", mem_raddr); end
        tick; ls_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL prio_second_grant: got %b expected 1", if_req_ready); end
        checks++; if (mem_raddr !== 32'h10) begin errors++; $display("FAIL prio_second_raddr: got %h expected 10", mem_raddr); end
        tick; if_req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ls_rsp_valid && ls_at < 0) begin
                ls_at = k;
                checks++; if (ls_rsp_data !== f(32'h20)) begin errors++; $display("FAIL prio_ls_data: got %h expected %h", ls_rsp_data, f(32'h20)); end
            end
            if (if_rsp_valid && if_at < 0) begin
                if_at = k;
                checks++; if ({if_rsp_tag, if_rsp_data} !== {32'hAB, f(32'h10)}) begin errors++; $display("FAIL prio_if_rsp: got %h/%h expected ab/%h", if_rsp_tag, if_rsp_data, f(32'h10)); end
            end
            tick;
        end
        checks++; if (!(ls_at >= 0 && if_at > ls_at)) begin errors++; $display("FAIL prio_order: got ls@%0d if@%0d expected ls before if", ls_at, if_at); end
    endtask

    task automatic test_starvation;
        lat = 1;
        if_req_valid = 1'b1; if_req_addr = 32'h100; if_req_tag = 32'h55;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if ({if_req_ready, ls_req_ready} !== ((i == 4) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL starve_grant_%0d: got if/ls %b expected %b", i, {if_req_ready, ls_req_ready}, (i == 4) ? 2'b10 : 2'b01); end
            tick;
            if (i == 4) if_req_valid = 1'b0;
            else ls_req_addr += 4;
        end
        ls_req_valid = 1'b0;
        repeat (8) tick;
    endtask

    task automatic test_fifo_full;
        lat = 1; mem_stall = 1'b1;
        ls_req_valid = 1'b1; ls_req_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ls_req_addr = 32'h300 + 32'(4 * (i < 2 ? i : 2));
            @(negedge clk);
            checks++; if (ls_req_ready !== (i < 2)) begin errors++; $display("FAIL full_grant_%0d: got %b expected %b", i, ls_req_ready, i < 2); end
            if (i == 4) mem_stall = 1'b0;
            tick;
        end
        @(negedge clk);
        checks++; if ({ls_rsp_valid, ls_req_ready} !== 2'b11) begin errors++; $display("FAIL full_pop_grant: got rsp/ready %b expected 11", {ls_rsp_valid, ls_req_ready}); end
        checks++; if (ls_rsp_data !== f(32'h300)) begin errors++; $display("FAIL full_pop_data: got %h expected %h", ls_rsp_data, f(32'h300)); end
        tick; ls_req_valid = 1'b0;
        repeat (8) tick;
    endtask

    task automatic test_flush;
        int ifn = 0, lsn = 0;
        bit acc;
        lat = 3;
        if_req_valid = 1'b1; if_req_addr = 32'h400; if_req_tag = 32'h1;
        @(negedge clk);
        checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL flush_if_grant0: got %b expected 1", if_req_ready); end
        tick; if_req_addr = 32'h404; if_req_tag = 32'h2;
        @(negedge clk);
        checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL flush_if_grant1: got %b expected 1", if_req_ready); end
        tick; if_req_valid = 1'b0; flush = 1'b1;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h500;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if_rsp_valid) ifn++;
            if (ls_rsp_valid) begin
                lsn++;
                checks++; if (ls_rsp_data !== f(32'h500)) begin errors++; $display("FAIL flush_ls_data: got %h expected %h", ls_rsp_data, f(32'h500)); end
            end
            acc = ls_req_ready;
            tick; flush = 1'b0;
            if (acc) ls_req_valid = 1'b0;
        end
        checks++; if (ifn != 0) begin errors++; $display("FAIL flush_if_dropped: got %0d if responses expected 0", ifn); end
        checks++; if (lsn != 1) begin errors++; $display("FAIL flush_ls_count: got %0d ls responses expected 1", lsn); end
    endtask

    task automatic test_write_full;
        int lsn = 0;
        lat = 1; mem_stall = 1'b1;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h600;
        tick; ls_req_addr = 32'h604;
        tick; ls_req_we = 1'b1; ls_req_addr = 32'h40; ls_req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if ({ls_req_ready, mem_wen, mem_rvalid_in} !== 3'b110) begin errors++; $display("FAIL wr_strobes: got ready/wen/rd %b expected 110", {ls_req_ready, mem_wen, mem_rvalid_in}); end
        checks++; if ({mem_waddr, mem_wdata} !== {32'h40, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_bus: got %h/%h expected 40/deadbeef", mem_waddr, mem_wdata); end
        mem_stall = 1'b0;
        tick; ls_req_valid = 1'b0; ls_req_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ls_rsp_valid) lsn++;
            tick;
        end
        checks++; if (lsn != 2) begin errors++; $display("FAIL wr_no_push: got %0d ls responses expected 2", lsn); end
    endtask

    task automatic test_perf;
        @(negedge clk); rstn = 1'b0; mem_stall = 1'b1;
        tick; rstn = 1'b1; lat = 1;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'hB00;
        tick; ls_req_addr = 32'hB04;
        tick; ls_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'hC00; if_req_tag = 32'h9;
        repeat (7) tick;
        if_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (perf_if_stall !== (PERF ? 32'd7 : 32'd0)) begin errors++; $display("FAIL perf_if_stall: got %0d expected %0d", perf_if_stall, PERF ? 7 : 0); end
        checks++; if (perf_ls_stall !== 32'd0) begin errors++; $display("FAIL perf_ls_stall: got %0d expected 0", perf_ls_stall); end
        mem_stall = 1'b0;
        repeat (8) tick;
    endtask

    task automatic test_reset_midflight;
        int ifn = 0, lsn = 0;
        bit acc;
        lat = 3;
        if_req_valid = 1'b1; if_req_addr = 32'h800; if_req_tag = 32'h7;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h900;
        tick; ls_req_addr = 32'h904;
        tick; #2; rstn = 1'b0; #1;
        checks++; if ({if_req_ready, ls_req_ready, mem_rvalid_in, mem_wen, if_rsp_valid, ls_rsp_valid} !== 6'b0) begin errors++; $display("FAIL midrst_strobes: got %b expected 000000", {if_req_ready, ls_req_ready, mem_rvalid_in, mem_wen, if_rsp_valid, ls_rsp_valid}); end
        checks++; if ({mem_raddr, perf_if_stall, perf_ls_stall} !== 96'h0) begin errors++; $display("FAIL midrst_bus: got %h expected 0", {mem_raddr, perf_if_stall, perf_ls_stall}); end
        tick; rstn = 1'b1; if_req_valid = 1'b0; ls_req_addr = 32'hA00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if_rsp_valid) ifn++;
            if (ls_rsp_valid) begin
                lsn++;
                checks++; if (ls_rsp_data !== f(32'hA00)) begin errors++; $display("FAIL midrst_ls_data: got %h expected %h", ls_rsp_data, f(32'hA00)); end
            end
            acc = ls_req_ready;
            tick;
            if (acc) ls_req_valid = 1'b0;
        end
        checks++; if ({ifn, lsn} != {32'd0, 32'd1}) begin errors++; $display("FAIL midrst_fifo_empty: got if=%0d ls=%0d expected if=0 ls=1", ifn, lsn); end
    endtask

    task automatic test_random;
        bit ia = 1'b0, la = 1'b0;
        exp_t e;
        for (int i = 0; i < 600; i++) begin
            if (!if_req_valid || ia) begin
                if_req_valid = $urandom_range(0, 2) != 0;
                if_req_addr = $urandom;
                if_req_tag = $urandom;
            end
            if (!ls_req_valid || la) begin
                ls_req_valid = $urandom_range(0, 2) != 0;
                ls_req_we = $urandom_range(0, 3) == 0;
                ls_req_addr = $urandom;
                ls_req_wdata = $urandom;
            end
            flush = $urandom_range(0, 9) == 0;
            mem_stall = $urandom_range(0, 4) == 0;
            lat = $urandom_range(1, 3);
            @(negedge clk);
            e = model_exp();
            checks++; if ({if_req_ready, ls_req_ready, mem_rvalid_in, mem_wen, if_rsp_valid, ls_rsp_valid} !== {e.gi, e.gl, e.rd, e.wen, e.ifv, e.lsv}) begin errors++; $display("FAIL rnd_strobes@%0d: got %b expected %b", i, {if_req_ready, ls_req_ready, mem_rvalid_in, mem_wen, if_rsp_valid, ls_rsp_valid}, {e.gi, e.gl, e.rd, e.wen, e.ifv, e.lsv}); end
            if (e.rd) begin checks++; if (mem_raddr !== e.raddr) begin errors++; $display("FAIL rnd_raddr@%0d: got %h expected %h", i, mem_raddr, e.raddr); end end
            if (e.wen) begin checks++; if ({mem_waddr, mem_wdata} !== {e.waddr, e.wdata}) begin errors++; $display("FAIL rnd_write@%0d: got %h/%h expected %h/%h", i, mem_waddr, mem_wdata, e.waddr, e.wdata); end end
            if (e.lsv) begin checks++; if (ls_rsp_data !== e.lsd) begin errors++; $display("FAIL rnd_ls_data@%0d: got %h expected %h", i, ls_rsp_data, e.lsd); end end
            if (e.ifv) begin checks++; if ({if_rsp_tag, if_rsp_data} !== {e.ift, e.ifd}) begin errors++; $display("FAIL rnd_if_rsp@%0d: got %h/%h expected %h/%h", i, if_rsp_tag, if_rsp_data, e.ift, e.ifd); end end
            checks++; if ({perf_if_stall, perf_ls_stall} !== (PERF ? {32'(pif), 32'(pls)} : 64'h0)) begin errors++; $display("FAIL rnd_perf@%0d: got %0d/%0d expected %0d/%0d", i, perf_if_stall, perf_ls_stall, PERF ? pif : 0, PERF ? pls : 0); end
            ia = if_req_ready;
            la = ls_req_ready;
            tick;
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        repeat (8) tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_priority;
        test_starvation;
        test_fifo_full;
        test_flush;
        test_write_full;
        test_perf;
        test_reset_midflight;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
